mem_access_stage: RTL and testbench

//  Parametrised MEM pipeline stage. Executes loads/stores against a req/ack data-memory port with

---
 rtl/mem_access_stage_pkg.sv | 49 ++++
 rtl/mem_access_stage_load_align.sv | 34 +++
 rtl/mem_access_stage.sv | 202 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage defines: load/store op encodings, FSM states, access sizes
// and the reset values used by the write-back outputs.
package mem_access_stage_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam int NOP_REG_ADDR = 0;
    localparam int ZERO_WORD    = 0;

    function automatic logic op_is_load(input mem_op_e op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // "Word" means the full DATA_W bus width.
    function automatic size_e op_size(input mem_op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data formatter: picks the addressed byte/half lane out of the read word
// and sign- or zero-extends it; full-width loads pass straight through.
module mem_load_align
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 2
) (
    input  mem_op_e             i_op,
    input  logic [LANE_W-1:0]   i_lane,
    input  logic [DATA_W-1:0]   i_rdata,
    output logic [DATA_W-1:0]   o_data
);

    logic [DATA_W-1:0] w_shifted;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    assign w_shifted = i_rdata >> {i_lane, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_op)
            OP_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
            OP_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            OP_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores on a req/ack data port with bounded
// wait states, stalls upstream while busy and registers the write-back triple.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic                   wreg_i,
    input  logic [REG_ADDR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic [3:0]             mem_op_i,
    input  logic [ADDR_W-1:0]      mem_addr_i,
    input  logic [DATA_W-1:0]      mem_sdata_i,
    output logic                   stall_o,
    output logic                   d_req_o,
    output logic                   d_we_o,
    output logic [DATA_W/8-1:0]    d_be_o,
    output logic [ADDR_W-1:0]      d_addr_o,
    output logic [DATA_W-1:0]      d_wdata_o,
    input  logic                   d_ack_i,
    input  logic [DATA_W-1:0]      d_rdata_i,
    output logic                   wreg_o,
    output logic [REG_ADDR_W-1:0]  waddr_o,
    output logic [DATA_W-1:0]      wdata_o,
    output logic                   misalign_o,
    output logic                   bus_err_o,
    output state_e                 dbg_state_o
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam int CNT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(MAX_WAIT - 1);
    localparam logic [DATA_W-1:0]     ZERO      = DATA_W'(ZERO_WORD);
    localparam logic [REG_ADDR_W-1:0] NOP_WADDR = REG_ADDR_W'(NOP_REG_ADDR);

    state_e                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_req;
    logic                   r_we;
    logic [BE_W-1:0]        r_be;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    mem_op_e                r_op;
    logic [LANE_W-1:0]      r_lane;
    logic                   r_wreg;
    logic [REG_ADDR_W-1:0]  r_waddr;
    logic                   r_wreg_o;
    logic [REG_ADDR_W-1:0]  r_waddr_o;
    logic [DATA_W-1:0]      r_wdata_o;
    logic                   r_misalign;
    logic                   r_bus_err;

    mem_op_e                w_op;
    logic [LANE_W-1:0]      w_lane;
    size_e                  w_size;
    logic                   w_is_load;
    logic                   w_is_store;
    logic                   w_is_mem;
    logic                   w_misalign;
    logic                   w_start;
    logic [BE_W-1:0]        w_be;
    logic [DATA_W-1:0]      w_rep;
    logic [ADDR_W-1:0]      w_aligned_addr;
    logic [DATA_W-1:0]      w_load_data;

    assign w_op           = mem_op_e'(mem_op_i);
    assign w_lane         = mem_addr_i[LANE_W-1:0];
    assign w_size         = op_size(w_op);
    assign w_is_load      = op_is_load(w_op);
    assign w_is_store     = op_is_store(w_op);
    assign w_is_mem       = w_is_load | w_is_store;
    assign w_start        = valid_i & w_is_mem & ~w_misalign;
    assign w_aligned_addr = {mem_addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

    // Lane enables, alignment check and store-data replication per access size.
    always_comb begin
        w_misalign = 1'b0;
        w_be       = '0;
        w_rep      = '0;
        case (w_size)
            SZ_BYTE: begin
                w_be  = BE_W'(1) << w_lane;
                w_rep = {BE_W{mem_sdata_i[7:0]}};
            end
            SZ_HALF: begin
                w_misalign = w_lane[0];
                w_be       = BE_W'(3) << w_lane;
                w_rep      = {(BE_W/2){mem_sdata_i[15:0]}};
            end
            default: begin
                w_misalign = |w_lane;
                w_be       = '1;
                w_rep      = mem_sdata_i;
            end
        endcase
    end

    mem_load_align #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_load_align (
        .i_op    (r_op),
        .i_lane  (r_lane),
        .i_rdata (d_rdata_i),
        .o_data  (w_load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_addr     <= '0;
            r_wdata    <= ZERO;
            r_op       <= OP_NONE;
            r_lane     <= '0;
            r_wreg     <= 1'b0;
            r_waddr    <= NOP_WADDR;
            r_wreg_o   <= 1'b0;
            r_waddr_o  <= NOP_WADDR;
            r_wdata_o  <= ZERO;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!valid_i) begin
                        r_wreg_o <= 1'b0;
                    end else if (w_start) begin
                        r_state  <= ST_ACCESS;
                        r_cnt    <= '0;
                        r_req    <= 1'b1;
                        r_we     <= w_is_store;
                        r_be     <= w_be;
                        r_addr   <= w_aligned_addr;
                        r_wdata  <= w_rep;
                        r_op     <= w_op;
                        r_lane   <= w_lane;
                        r_wreg   <= wreg_i;
                        r_waddr  <= waddr_i;
                        r_wreg_o <= 1'b0;
                    end else if (w_is_mem) begin
                        r_wreg_o   <= 1'b0;
                        r_misalign <= 1'b1;
                    end else begin
                        r_wreg_o  <= wreg_i;
                        r_waddr_o <= waddr_i;
                        r_wdata_o <= wdata_i;
                    end
                end
                ST_ACCESS: begin
                    r_wreg_o <= 1'b0;
                    // An ack on the final wait cycle still counts as completion.
                    if (d_ack_i) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_wreg_o  <= r_wreg;
                            r_waddr_o <= r_waddr;
                            r_wdata_o <= w_load_data;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= ST_IDLE;
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Gated by reset so upstream is released the instant reset asserts.
    assign stall_o = rst & (((r_state == ST_IDLE) & w_start) |
                            ((r_state == ST_ACCESS) & ~d_ack_i));

    assign d_req_o     = r_req;
    assign d_we_o      = r_we;
    assign d_be_o      = r_be;
    assign d_addr_o    = r_addr;
    assign d_wdata_o   = r_wdata;
    assign wreg_o      = r_wreg_o;
    assign waddr_o     = r_waddr_o;
    assign wdata_o     = r_wdata_o;
    assign misalign_o  = r_misalign;
    assign bus_err_o   = r_bus_err;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, randomized transactions
// against a behavioural model, and reset / stale-ack sequences.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int MAX_WAIT = 15;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        wreg_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic        stall_o;
  logic        d_req_o;
  logic        d_we_o;
  logic [3:0]  d_be_o;
  logic [31:0] d_addr_o;
  logic [31:0] d_wdata_o;
  logic        d_ack_i;
  logic [31:0] d_rdata_i;
  logic        wreg_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        misalign_o;
  logic        bus_err_o;
  state_e      dbg_state;

  mem_access_stage #(
    .DATA_W     (32),
    .ADDR_W     (32),
    .REG_ADDR_W (5),
    .MAX_WAIT   (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .wreg_i      (wreg_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .mem_op_i    (mem_op_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sdata_i (mem_sdata_i),
    .stall_o     (stall_o),
    .d_req_o     (d_req_o),
    .d_we_o      (d_we_o),
    .d_be_o      (d_be_o),
    .d_addr_o    (d_addr_o),
    .d_wdata_o   (d_wdata_o),
    .d_ack_i     (d_ack_i),
    .d_rdata_i   (d_rdata_i),
    .wreg_o      (wreg_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- records ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waits;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          e_stall;
    int          e_req;
    logic [3:0]  e_be;
    logic [31:0] e_baddr;
    logic [31:0] e_bwdata;
    logic        e_we;
    logic        e_wreg;
    logic        e_wchk;
    logic [31:0] e_wdata;
    logic        e_mis;
    logic        e_err;
  } vec_t;

  typedef struct {
    int          stall;
    int          req;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic        we;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mis;
    logic        err;
    logic        idle;
    logic        stall_after;
    logic        req_after;
    logic        mis_next;
    logic        err_next;
    logic        wreg_next;
  } obs_t;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
    input logic [31:0] rdata, input int waits, input logic wreg,
    input logic [4:0] waddr, input logic [31:0] wdata,
    input int e_stall, input int e_req, input logic [3:0] e_be,
    input logic [31:0] e_baddr, input logic [31:0] e_bwdata, input logic e_we,
    input logic e_wreg, input logic e_wchk, input logic [31:0] e_wdata,
    input logic e_mis, input logic e_err);
    vec_t v;
    v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.waits = waits;
    v.wreg = wreg; v.waddr = waddr; v.wdata = wdata;
    v.e_stall = e_stall; v.e_req = e_req; v.e_be = e_be; v.e_baddr = e_baddr;
    v.e_bwdata = e_bwdata; v.e_we = e_we; v.e_wreg = e_wreg; v.e_wchk = e_wchk;
    v.e_wdata = e_wdata; v.e_mis = e_mis; v.e_err = e_err;
    return v;
  endfunction

  // Reference model: derives the expected outcome from size/offset arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    int     size;
    int     off;
    bit     sgn;
    bit     ld;
    bit     st;
    longint val;
    r = v;
    size = 4; sgn = 0; ld = 0; st = 0;
    r.e_stall = 0; r.e_req = 0; r.e_be = '0; r.e_baddr = '0; r.e_bwdata = '0;
    r.e_we = 0; r.e_wreg = 0; r.e_wchk = 0; r.e_wdata = '0; r.e_mis = 0; r.e_err = 0;
    case (v.op)
      4'd1: begin size = 1; sgn = 1; ld = 1; end
      4'd2: begin size = 1; ld = 1; end
      4'd3: begin size = 2; sgn = 1; ld = 1; end
      4'd4: begin size = 2; ld = 1; end
      4'd5: begin size = 4; ld = 1; end
      4'd6: begin size = 1; st = 1; end
      4'd7: begin size = 2; st = 1; end
      4'd8: begin size = 4; st = 1; end
      default: ;
    endcase
    off = int'(v.addr % 32'd4);
    if (!ld && !st) begin
      r.e_wreg = v.wreg; r.e_wchk = 1; r.e_wdata = v.wdata;
    end else if (off % size != 0) begin
      r.e_mis = 1;
    end else begin
      r.e_be    = 4'(((1 << size) - 1) << off);
      r.e_baddr = v.addr - 32'(off);
      for (int i = 0; i < 4; i++)
        r.e_bwdata[8*i +: 8] = 8'((v.sdata >> (8 * (i % size))) & 32'hFF);
      r.e_we = st;
      if (v.waits < MAX_WAIT) begin
        r.e_req = v.waits + 1; r.e_stall = v.waits + 1;
        if (ld) begin
          val = longint'(v.rdata >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
          if (sgn && val >= longint'(64'd1 << (8 * size - 1))) val = val - longint'(64'd1 << (8 * size));
          r.e_wdata = 32'(val); r.e_wreg = v.wreg; r.e_wchk = 1;
        end
      end else begin
        r.e_req = MAX_WAIT; r.e_stall = MAX_WAIT + 1; r.e_err = 1;
      end
    end
    return r;
  endfunction

  // ---------------- driver ----------------
  // Starts at a negedge with valid_i low; holds the entry while stall_o is
  // high and acks on request cycle number v.waits (never if >= MAX_WAIT).
  task automatic run_txn(input vec_t v, output obs_t o);
    int   n;
    int   guard;
    logic prev_stall;
    logic prev_req;
    o = '{default: 0};
    valid_i = 1'b1; mem_op_i = v.op; mem_addr_i = v.addr; mem_sdata_i = v.sdata;
    d_rdata_i = v.rdata; wreg_i = v.wreg; waddr_i = v.waddr; wdata_i = v.wdata;
    n = 0; prev_stall = 1'b1; prev_req = 1'b0;
    for (guard = 0; guard < 40; guard++) begin
      if (n > 0 && (!prev_stall || (prev_req && !d_req_o))) break;
      if (d_req_o) begin
        o.req++;
        o.be = d_be_o; o.baddr = d_addr_o; o.bwdata = d_wdata_o; o.we = d_we_o;
        d_ack_i = ((o.req - 1) == v.waits);
      end else begin
        d_ack_i = 1'b0;
      end
      #1;
      if (stall_o) o.stall++;
      prev_stall = stall_o; prev_req = d_req_o; n++;
      @(negedge clk);
    end
    if (guard >= 40) chk("txn_cycle_budget_exceeded", 1, 0);
    valid_i = 1'b0; d_ack_i = 1'b0;
    #1;
    o.wreg = wreg_o; o.waddr = waddr_o; o.wdata = wdata_o;
    o.mis = misalign_o; o.err = bus_err_o; o.idle = (dbg_state == ST_IDLE);
    o.stall_after = stall_o; o.req_after = d_req_o;
    @(negedge clk);
    #1;
    o.mis_next = misalign_o; o.err_next = bus_err_o; o.wreg_next = wreg_o;
  endtask

  task automatic compare(input string tag, input vec_t v, input obs_t o);
    chk({tag, " stall_cycles"}, o.stall, v.e_stall);
    chk({tag, " req_cycles"}, o.req, v.e_req);
    if (v.e_req > 0 && o.req > 0) begin
      chk({tag, " d_be"}, o.be, v.e_be);
      chk({tag, " d_addr"}, o.baddr, v.e_baddr);
      chk({tag, " d_wdata"}, o.bwdata, v.e_bwdata);
      chk({tag, " d_we"}, o.we, v.e_we);
    end
    chk({tag, " wreg_o"}, o.wreg, v.e_wreg);
    if (v.e_wchk) begin
      chk({tag, " waddr_o"}, o.waddr, v.waddr);
      chk({tag, " wdata_o"}, o.wdata, v.e_wdata);
    end
    chk({tag, " misalign_o"}, o.mis, v.e_mis);
    chk({tag, " bus_err_o"}, o.err, v.e_err);
    chk({tag, " state_idle"}, o.idle, 1);
    chk({tag, " stall_after"}, o.stall_after, 0);
    chk({tag, " req_after"}, o.req_after, 0);
    chk({tag, " misalign_pulse_end"}, o.mis_next, 0);
    chk({tag, " bus_err_pulse_end"}, o.err_next, 0);
    chk({tag, " bubble_wreg"}, o.wreg_next, 0);
  endtask

  // ---------------- test ----------------
  vec_t vecs[15];
  vec_t rv;
  obs_t ob;

  initial begin
    vecs[0]  = mk(OP_NONE, 32'h0,   32'h0,        32'h0,        0,  1'b1, 5'd5,  32'h1234, 0,  0,  4'b0000, 32'h0,   32'h0,        1'b0, 1'b1, 1'b1, 32'h1234,     1'b0, 1'b0);
    vecs[1]  = mk(OP_LB,   32'h102, 32'h11,       32'h8899AABB, 3,  1'b1, 5'd7,  32'h0,    4,  4,  4'b0100, 32'h100, 32'h11111111, 1'b0, 1'b1, 1'b1, 32'hFFFFFF99, 1'b0, 1'b0);
    vecs[2]  = mk(OP_LBU,  32'h102, 32'h11,       32'h8899AABB, 3,  1'b1, 5'd7,  32'h0,    4,  4,  4'b0100, 32'h100, 32'h11111111, 1'b0, 1'b1, 1'b1, 32'h00000099, 1'b0, 1'b0);
    vecs[3]  = mk(OP_SH,   32'h202, 32'h0000BEEF, 32'h0,        0,  1'b1, 5'd3,  32'h0,    1,  1,  4'b1100, 32'h200, 32'hBEEFBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    vecs[4]  = mk(OP_LW,   32'h301, 32'h0,        32'h0,        0,  1'b1, 5'd4,  32'h0,    0,  0,  4'b0000, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0);
    vecs[5]  = mk(OP_LW,   32'h300, 32'hCAFEF00D, 32'h5,        99, 1'b1, 5'd6,  32'h0,    16, 15, 4'b1111, 32'h300, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1);
    vecs[6]  = mk(OP_LH,   32'h106, 32'h1234,     32'h80017FFF, 1,  1'b1, 5'd8,  32'h0,    2,  2,  4'b1100, 32'h104, 32'h12341234, 1'b0, 1'b1, 1'b1, 32'hFFFF8001, 1'b0, 1'b0);
    vecs[7]  = mk(OP_LHU,  32'h106, 32'h1234,     32'h80017FFF, 1,  1'b1, 5'd8,  32'h0,    2,  2,  4'b1100, 32'h104, 32'h12341234, 1'b0, 1'b1, 1'b1, 32'h00008001, 1'b0, 1'b0);
    vecs[8]  = mk(OP_LW,   32'h40C, 32'h0,        32'hA5A55A5A, 14, 1'b1, 5'd9,  32'h0,    15, 15, 4'b1111, 32'h40C, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA5A55A5A, 1'b0, 1'b0);
    vecs[9]  = mk(OP_SB,   32'h003, 32'hA5,       32'h0,        2,  1'b1, 5'd10, 32'h0,    3,  3,  4'b1000, 32'h000, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    vecs[10] = mk(OP_SW,   32'h040, 32'h12345678, 32'h0,        0,  1'b0, 5'd11, 32'h0,    1,  1,  4'b1111, 32'h040, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0);
    vecs[11] = mk(OP_LH,   32'h101, 32'h0,        32'h0,        0,  1'b1, 5'd1,  32'h0,    0,  0,  4'b0000, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0);
    vecs[12] = mk(OP_NONE, 32'h0,   32'h0,        32'h0,        0,  1'b0, 5'd9,  32'hDEAD, 0,  0,  4'b0000, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 32'hDEAD,     1'b0, 1'b0);
    vecs[13] = mk(OP_SH,   32'h203, 32'h0,        32'h0,        0,  1'b1, 5'd2,  32'h0,    0,  0,  4'b0000, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0);
    vecs[14] = mk(OP_LB,   32'h0FF, 32'h0,        32'h7F000000, 0,  1'b1, 5'd12, 32'h0,    1,  1,  4'b1000, 32'h0FC, 32'h00000000, 1'b0, 1'b1, 1'b1, 32'h0000007F, 1'b0, 1'b0);

    rst = 1'b0; valid_i = 1'b0; wreg_i = 1'b0; waddr_i = '0; wdata_i = '0;
    mem_op_i = '0; mem_addr_i = '0; mem_sdata_i = '0; d_ack_i = 1'b0; d_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset stall_o", stall_o, 0);
    chk("reset d_req_o", d_req_o, 0);
    chk("reset d_we_o", d_we_o, 0);
    chk("reset d_be_o", d_be_o, 0);
    chk("reset d_addr_o", d_addr_o, 0);
    chk("reset d_wdata_o", d_wdata_o, 0);
    chk("reset wreg_o", wreg_o, 0);
    chk("reset waddr_o", waddr_o, 0);
    chk("reset wdata_o", wdata_o, 0);
    chk("reset misalign_o", misalign_o, 0);
    chk("reset bus_err_o", bus_err_o, 0);
    chk("reset state_idle", dbg_state == ST_IDLE, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Ack while idle must be ignored.
    d_ack_i = 1'b1; d_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    d_ack_i = 1'b0;
    #1;
    chk("idle_ack wreg_o", wreg_o, 0);
    chk("idle_ack d_req_o", d_req_o, 0);
    chk("idle_ack state_idle", dbg_state == ST_IDLE, 1);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      run_txn(vecs[i], ob);
      compare($sformatf("vec%0d", i), vecs[i], ob);
    end

    for (int k = 0; k < 80; k++) begin
      rv.op    = 4'($urandom_range(0, 8));
      rv.addr  = $urandom;
      if ($urandom_range(0, 1) == 1) rv.addr[1:0] = 2'b00;
      rv.sdata = $urandom;
      rv.rdata = $urandom;
      rv.waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 4));
      rv.wreg  = 1'($urandom_range(0, 1));
      rv.waddr = 5'($urandom_range(0, 31));
      rv.wdata = $urandom;
      rv = model(rv);
      run_txn(rv, ob);
      compare($sformatf("rand%0d", k), rv, ob);
    end

    // Reset in the middle of an access, then a stale ack after release.
    valid_i = 1'b1; mem_op_i = OP_LW; mem_addr_i = 32'h500; wreg_i = 1'b1;
    waddr_i = 5'd17; d_rdata_i = 32'h13572468; d_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("midreset pre d_req_o", d_req_o, 1);
    rst = 1'b0;
    #1;
    chk("midreset d_req_o", d_req_o, 0);
    chk("midreset stall_o", stall_o, 0);
    chk("midreset state_idle", dbg_state == ST_IDLE, 1);
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    d_ack_i = 1'b1;
    @(negedge clk);
    d_ack_i = 1'b0;
    #1;
    chk("stale_ack wreg_o", wreg_o, 0);
    chk("stale_ack d_req_o", d_req_o, 0);
    chk("stale_ack stall_o", stall_o, 0);
    chk("stale_ack state_idle", dbg_state == ST_IDLE, 1);
    @(negedge clk);
    #1;
    chk("stale_ack wreg_o later", wreg_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
